// File: rtl/reg_bank_pkg.sv
// Shared definitions for the arbitrated register bank: FSM encoding and
// the address/pointer width helper.
package reg_bank_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // Ceiling log2, never less than 1 so a one-word bank still has an address bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side bus of the shared register bank: packed per-requester
// request/operand vectors in, one-hot grant/ack and shared read data out.
interface reg_bank_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);

   localparam int AW = reg_bank_pkg::clog2(DEPTH);

   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       we;
   logic [NREQ*AW-1:0]    addr;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      rdata;
   logic                  busy;

   modport master (
      output req, we, addr, wdata,
      input  gnt, ack, rdata, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, ack, rdata, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping from NREQ-1 back to 0.
module rr_arbiter
   import reg_bank_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int PW   = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt_next,
   output logic [PW-1:0]   winner,
   output logic            any
);

   int idx;

   always_comb begin
      // NOTE: every output gets a default before any conditional assignment;
      // a path that leaves one unassigned would infer a latch.
      winner   = '0;
      gnt_next = '0;
      idx      = 0;
      any      = |req;
      // Walk from the farthest offset down so the closest request to ptr wins last.
      for (int off = NREQ - 1; off >= 0; off--) begin
         idx = (int'(ptr) + off) % NREQ;
         if (req[idx]) winner = PW'(idx);
      end
      if (any) gnt_next = NREQ'(1) << winner;
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NREQ requesters: round-robin grant, one access
// cycle against the internal storage, then a one-cycle ack.
module reg_bank_arbiter
   import reg_bank_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input logic               clk,
   input logic               rst_n,
   reg_bank_arbiter_if.slave bus
);

   localparam int AW = clog2(DEPTH);
   localparam int PW = clog2(NREQ);

   logic [1:0]       state;
   logic [NREQ-1:0]  gnt_q;
   logic [NREQ-1:0]  ack_q;
   logic [WIDTH-1:0] rdata_q;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    winner_q;
   logic             lat_we;
   logic [AW-1:0]    lat_addr;
   logic [WIDTH-1:0] lat_wdata;
   logic [WIDTH-1:0] mem [DEPTH];

   logic [NREQ-1:0]  arb_gnt;
   logic [PW-1:0]    arb_winner;
   logic             arb_any;
   logic             addr_ok;

   rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
      .req      (bus.req),
      .ptr      (rr_ptr),
      .gnt_next (arb_gnt),
      .winner   (arb_winner),
      .any      (arb_any)
   );

   // Only a non-power-of-2 bank has address codes with no backing word.
   generate
      if (DEPTH == (1 << AW)) begin : g_full_range
         assign addr_ok = 1'b1;
      end else begin : g_part_range
         assign addr_ok = ({1'b0, lat_addr} < (AW + 1)'(DEPTH));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         gnt_q     <= '0;
         ack_q     <= '0;
         rdata_q   <= '0;
         rr_ptr    <= '0;
         winner_q  <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         // NOTE: the storage words are architecturally cleared by reset, so the
         // array is reset here like any other state rather than left to a RAM.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout so every register here
         // samples values from before the edge, independent of statement order.
         case (state)
            ST_IDLE: begin
               if (arb_any) begin
                  gnt_q     <= arb_gnt;
                  winner_q  <= arb_winner;
                  lat_we    <= bus.we[arb_winner];
                  lat_addr  <= bus.addr[arb_winner*AW +: AW];
                  lat_wdata <= bus.wdata[arb_winner*WIDTH +: WIDTH];
                  state     <= ST_ACCESS;
               end
            end

            ST_ACCESS: begin
               if (lat_we) begin
                  if (addr_ok) mem[lat_addr] <= lat_wdata;
               end else begin
                  rdata_q <= addr_ok ? mem[lat_addr] : '0;
               end
               ack_q  <= gnt_q;
               gnt_q  <= '0;
               rr_ptr <= (winner_q == PW'(NREQ - 1)) ? '0 : winner_q + PW'(1);
               state  <= ST_DONE;
            end

            ST_DONE: begin
               ack_q <= '0;
               state <= ST_IDLE;
            end

            default: begin
               gnt_q <= '0;
               ack_q <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;
   assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, single access, round-robin
// order, pointer wrap, mid-access reset and operand latching.
module tb_reg_bank_arbiter;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   reg_bank_arbiter_if #(.NREQ(4), .WIDTH(8), .DEPTH(8)) bus ();

   reg_bank_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction by a lone requester i, checking exact latency.
   task automatic do_txn(input int i, input bit w, input int a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input string tag);
      logic [3:0] oh;
      oh = 4'b0001 << i;
      bus.we[i]            = w;
      bus.addr[i*3 +: 3]   = 3'(a);
      bus.wdata[i*8 +: 8]  = d;
      bus.req[i]           = 1'b1;
      tick();
      check({tag, "_gnt"}, 32'(bus.gnt), 32'(oh));
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      tick();
      check({tag, "_ack"}, 32'(bus.ack), 32'(oh));
      check({tag, "_gnt_clr"}, 32'(bus.gnt), 32'd0);
      if (!w) check({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_rd));
      bus.req[i] = 1'b0;
      tick();
      check({tag, "_ack_clr"}, 32'(bus.ack), 32'd0);
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int w;
      int ph;
      logic [3:0] exp_g;
      logic [3:0] exp_a;
      logic [7:0] exp_rd;

      n_cmp     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      bus.req   = '0;
      bus.we    = '0;
      bus.addr  = '0;
      bus.wdata = '0;

      // 1. reset
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_gnt",   32'(bus.gnt),   32'd0);
      check("rst_ack",   32'(bus.ack),   32'd0);
      check("rst_rdata", 32'(bus.rdata), 32'd0);
      check("rst_busy",  32'(bus.busy),  32'd0);
      do_txn(0, 1'b0, 3, 8'h00, 8'h00, "t1_rd3");

      // 2. single write then read
      do_txn(1, 1'b1, 2, 8'hA5, 8'h00, "t2_wr2");
      do_txn(1, 1'b0, 2, 8'h00, 8'hA5, "t2_rd2");
      do_txn(3, 1'b0, 2, 8'h00, 8'hA5, "t2_rd2_r3");

      // 3. round-robin with all four holding req; requester i reads addr i
      for (int i = 0; i < 4; i++) begin
         bus.we[i]          = 1'b0;
         bus.addr[i*3 +: 3] = 3'(i);
      end
      bus.req = 4'b1111;
      for (int k = 0; k < 15; k++) begin
         tick();
         w      = (k / 3) % 4;
         ph     = k % 3;
         exp_g  = (ph == 0) ? (4'b0001 << w) : 4'b0000;
         exp_a  = (ph == 1) ? (4'b0001 << w) : 4'b0000;
         exp_rd = (w == 2) ? 8'hA5 : 8'h00;
         check($sformatf("t3_gnt_k%0d", k), 32'(bus.gnt), 32'(exp_g));
         check($sformatf("t3_ack_k%0d", k), 32'(bus.ack), 32'(exp_a));
         if (ph == 1) check($sformatf("t3_rdata_k%0d", k), 32'(bus.rdata), 32'(exp_rd));
      end
      bus.req = 4'b0000;

      // 4. pointer wrap: serve 3, then 0 and 3 together -> 0 first
      do_txn(3, 1'b0, 0, 8'h00, 8'h00, "t4_rd0_r3");
      bus.addr[0 +: 3] = 3'd2;
      bus.addr[9 +: 3] = 3'd2;
      bus.req = 4'b1001;
      tick();
      check("t4_gnt0", 32'(bus.gnt), 32'h1);
      tick();
      check("t4_ack0", 32'(bus.ack), 32'h1);
      check("t4_rdata0", 32'(bus.rdata), 32'hA5);
      bus.req[0] = 1'b0;
      tick();
      check("t4_done_gnt", 32'(bus.gnt), 32'h0);
      tick();
      check("t4_gnt3", 32'(bus.gnt), 32'h8);
      tick();
      check("t4_ack3", 32'(bus.ack), 32'h8);
      bus.req[3] = 1'b0;
      tick();

      // 5. async reset between grant edge and access edge
      bus.we[2]          = 1'b1;
      bus.addr[6 +: 3]   = 3'd5;
      bus.wdata[16 +: 8] = 8'h3C;
      bus.req[2]         = 1'b1;
      tick();
      check("t5_gnt", 32'(bus.gnt), 32'h4);
      #3;
      rst_n = 1'b0;
      #1;
      check("t5_rst_gnt",  32'(bus.gnt),  32'd0);
      check("t5_rst_ack",  32'(bus.ack),  32'd0);
      check("t5_rst_busy", 32'(bus.busy), 32'd0);
      bus.req = 4'b0000;
      tick();
      tick();
      rst_n = 1'b1;
      do_txn(0, 1'b0, 5, 8'h00, 8'h00, "t5_rd5");

      // 6. operands latched at the grant edge
      bus.we[0]         = 1'b1;
      bus.addr[0 +: 3]  = 3'd1;
      bus.wdata[0 +: 8] = 8'h11;
      bus.req[0]        = 1'b1;
      tick();
      check("t6_gnt", 32'(bus.gnt), 32'h1);
      bus.wdata[0 +: 8] = 8'hFF;
      bus.addr[0 +: 3]  = 3'd3;
      tick();
      check("t6_ack", 32'(bus.ack), 32'h1);
      bus.req[0] = 1'b0;
      tick();
      do_txn(1, 1'b0, 1, 8'h00, 8'h11, "t6_rd1");
      do_txn(1, 1'b0, 3, 8'h00, 8'h00, "t6_rd3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Shares one bank of D-type storage registers (DEPTH words x WIDTH bits) between NREQ requesters.
- Round-robin arbitration picks one requester per transaction.
- The granted requester's read or write is performed against the bank, then it receives a one-cycle ack.
- Sits between the requesting datapath blocks and the flip-flop storage; the bank is internal to this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width of each storage word.
- DEPTH, 8, number of storage words; AW = clog2(DEPTH), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request; held high until ack.
- we  input  NREQ  per-requester op: 1 = write, 0 = read; held with req.
- addr  input  NREQ*AW  packed addresses; requester i uses slice [i*AW +: AW].
- wdata  input  NREQ*WIDTH  packed write data; requester i uses slice [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot registered grant.
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- rdata  output  WIDTH  read data; valid while ack is high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous and active-low.
- Reset values: state = IDLE, gnt = 0, ack = 0, rdata = 0, busy = 0, rr pointer = 0, all DEPTH words = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If |req at a clk edge: winner = first asserted req scanning upward from the rr pointer, wrapping NREQ-1 -> 0.
  - At that edge: gnt <= onehot(winner); winner's we, addr and wdata are latched; next state ACCESS.
  - If no req, stay in IDLE with all outputs low.
- ACCESS (gnt high, one cycle), at the clk edge:
  - Write: mem[addr] <= wdata; rdata is left unchanged.
  - Read: rdata <= mem[addr].
  - ack <= gnt; gnt <= 0; rr pointer <= (winner+1) mod NREQ; next state DONE.
- DONE (ack high, one cycle): ack <= 0 at the next edge; next state IDLE. req is not sampled in DONE.
- Latency:
  - req sampled at edge E0 -> gnt high in cycle E0..E1.
  - ack and rdata valid in cycle E1..E2.
  - Next arbitration at E3 at the earliest.
  - Throughput: one transaction per 3 cycles.
- Requester protocol:
  - Hold req, we, addr and wdata stable until ack.
  - Drop req in the ack cycle unless a further transaction is wanted.
  - A req still high in IDLE after DONE is treated as a new request.
- Operand latching: we, addr and wdata are latched at the grant edge. Changes after grant have no effect.
- req dropped after grant: the transaction still completes and ack is still issued.
- Out-of-range address (addr >= DEPTH, non-power-of-2 DEPTH only):
  - Write is discarded.
  - Read returns rdata = 0.
  - ack is still issued.
- Fairness: the winner moves to lowest priority after each transaction. With all NREQ requesting continuously, each requester is served once every 3*NREQ cycles.
- Reset mid-operation: asserting rst_n low in ACCESS or DONE aborts immediately. No write occurs unless the ACCESS edge has already passed. All outputs and state return to reset values.
- Read-after-write: a read granted after a write ack returns the new value.

Decomposition:
- Shared package reg_bank_pkg:
  - state encoding constants ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2;
  - clog2 function for AW.
- Sub-module rr_arbiter:
  - purely combinational; inputs req[NREQ] and ptr[clog2(NREQ)];
  - outputs onehot gnt_next, winner index, any.
- The FSM, operand latches and storage array stay in reg_bank_arbiter.

Test Plan:
1. Reset: hold rst_n = 0 for 2 cycles, then release -> gnt = 0, ack = 0, rdata = 0, busy = 0; a read of addr 3 by req[0] returns 8'h00.
2. Single write/read: req[1] writes 8'hA5 to addr 2, then reads addr 2 -> gnt[1] the cycle after the request, ack[1] one cycle later, rdata = 8'hA5 on the read ack.
3. Round-robin: req = 4'b1111 held, each requester re-requesting after its ack -> ack order 0,1,2,3,0 at 3-cycle spacing, never two bits set.
4. Pointer wrap: after requester 3 is served, req = 4'b1001 -> requester 0 is granted before 3.
5. Async reset mid-ACCESS: req[2] write 8'h3C to addr 5; drop rst_n between the grant edge and the ACCESS edge -> gnt and ack cleared immediately; a later read of addr 5 returns 8'h00.
6. Operand change after grant: requester 0 writes 8'h11 to addr 1; change wdata to 8'hFF in the gnt cycle -> a read of addr 1 returns 8'h11.
